// File: rtl/mips_reg_file_reader.sv
// MIPS general-purpose register file: two registered read ports (rs, rt) for decode
// and one write-back port, with write-first bypass and hard-wired zero register.
module mips_reg_file_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rd_valid
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic              rd_valid_q, rd_valid_d;

    // Index 0 reads as zero; a same-cycle write to the index wins over storage.
    function automatic logic [DATA_W-1:0] read_value(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        logic [DATA_W-1:0] v;
        if (a == {ADDR_W{1'b0}}) begin
            v = {DATA_W{1'b0}};
        end else if (we && (wa == a)) begin
            v = wd;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    // Next storage contents: write-back updates one word, index 0 is never written.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && (wr_addr != {ADDR_W{1'b0}})) begin
            mem_d[wr_addr] = wr_data;
        end else begin
            mem_d = mem_q;
        end
    end

    // Next read-port values: data holds while idle, valid pulses only on a read.
    always_comb begin
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        rd_valid_d = 1'b0;
        if (rd_en) begin
            rs_data_d  = read_value(rs_addr, mem_q[rs_addr], wr_en, wr_addr, wr_data);
            rt_data_d  = read_value(rt_addr, mem_q[rt_addr], wr_en, wr_addr, wr_data);
            rd_valid_d = 1'b1;
        end else begin
            rd_valid_d = 1'b0;
        end
    end

    // State update; reset clears everything and discards that cycle's requests.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            rs_data_q  <= {DATA_W{1'b0}};
            rt_data_q  <= {DATA_W{1'b0}};
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rs_data  = rs_data_q;
    assign rt_data  = rt_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_mips_reg_file_reader.sv
// Randomized scoreboard bench for mips_reg_file_reader: the driver pushes the
// expected registered outputs per cycle, a monitor pops and compares after each edge.
module tb_mips_reg_file_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_en;
    logic [4:0]  rs_addr, rt_addr, wr_addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] rs_data, rt_data;
    logic        rd_valid;

    mips_reg_file_reader #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rs_data(rs_data), .rt_data(rt_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] rs;
        logic [31:0] rt;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_regs [32];
    logic [31:0] last_rs = 32'd0;
    logic [31:0] last_rt = 32'd0;
    int          n_vec = 0;
    int          n_bad = 0;
    string       cur_tag = "init";

    // Reference value of a register as seen by a read issued this cycle.
    function automatic logic [31:0] ref_value(input logic [4:0] a, input logic we,
                                              input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return model_regs[a];
    endfunction

    task automatic step(input logic rst, input logic rd, input logic [4:0] rs,
                        input logic [4:0] rt, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        reset = rst; rd_en = rd; rs_addr = rs; rt_addr = rt;
        wr_en = we; wr_addr = wa; wr_data = wd;
        e.tag = cur_tag;
        if (!rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
            last_rs = 32'd0; last_rt = 32'd0;
            e.v = 1'b0;
        end else begin
            if (rd) begin
                last_rs = ref_value(rs, we, wa, wd);
                last_rt = ref_value(rt, we, wa, wd);
            end
            e.v = rd;
            if (we && wa != 5'd0) model_regs[wa] = wd;
        end
        e.rs = last_rs; e.rt = last_rt;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Monitor: one expected entry matures per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (rd_valid !== e.v || rs_data !== e.rs || rt_data !== e.rt) begin
                    n_bad++;
                    $display("FAIL %s: got valid=%0b rs=%h rt=%h, expected valid=%0b rs=%h rt=%h",
                             e.tag, rd_valid, rs_data, rt_data, e.v, e.rs, e.rt);
                end
            end
        end
    end

    initial begin
        logic [4:0] ra, rb, wa;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        reset = 1'b0; rd_en = 1'b0; rs_addr = 5'd0; rt_addr = 5'd0;
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;

        cur_tag = "reset";
        step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b1, 5'd5, 5'd31, 1'b0, 5'd0, 32'd0);
        idle();

        cur_tag = "write_then_read";
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h0000_0002);
        step(1'b1, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0);
        idle();

        cur_tag = "bypass";
        step(1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 32'd5);
        idle();

        cur_tag = "reg0";
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        idle();

        cur_tag = "streaming";
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'(i), 32'(i));
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 5'(i), 5'(5 - i), 1'b0, 5'd0, 32'd0);
        idle();
        idle();

        cur_tag = "reset_mid";
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'd8);
        step(1'b0, 1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 32'd0);
        idle();

        cur_tag = "random";
        for (int n = 0; n < 3000; n++) begin
            ra = 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            wa = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), ra, rb,
                 ($urandom_range(0, 1) == 1), wa, $urandom());
        end
        idle();

        for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
